// File: rtl/pipe_if_id.sv
// IF/ID pipeline register with a one-entry skid buffer.
// The main entry drives the decode outputs directly from flops. The skid entry
// catches a beat accepted while decode stalls, so f_ready can come straight
// from a flop instead of depending combinationally on d_ready.
module pipe_if_id #(
  parameter int unsigned   XLEN     = 32,
  parameter int unsigned   ILEN     = 32,
  parameter logic [ILEN-1:0] NOP_INST = ILEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            f_valid,
  output logic            f_ready,
  input  logic [ILEN-1:0] inst_f,
  input  logic [XLEN-1:0] pc_f,
  input  logic [XLEN-1:0] pc_plus_4_f,
  output logic            d_valid,
  input  logic            d_ready,
  output logic [ILEN-1:0] inst_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus_4_d
);

  logic            main_valid_q, main_valid_d;
  logic [ILEN-1:0] main_inst_q, main_inst_d;
  logic [XLEN-1:0] main_pc_q, main_pc_d;
  logic [XLEN-1:0] main_pc4_q, main_pc4_d;
  logic            skid_valid_q, skid_valid_d;
  logic [ILEN-1:0] skid_inst_q, skid_inst_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_pc4_q, skid_pc4_d;
  logic            accept_c;
  logic            xfer_c;

  // Handshake qualifiers; f_ready depends only on the skid flop.
  assign f_ready  = ~skid_valid_q;
  assign accept_c = f_valid & ~skid_valid_q;
  assign xfer_c   = main_valid_q & d_ready;

  assign d_valid     = main_valid_q;
  assign inst_d      = main_inst_q;
  assign pc_d        = main_pc_q;
  assign pc_plus_4_d = main_pc4_q;

  // Next-state for both entries; flush overrides any accept or transfer.
  always_comb begin
    main_valid_d = main_valid_q;
    main_inst_d  = main_inst_q;
    main_pc_d    = main_pc_q;
    main_pc4_d   = main_pc4_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    skid_pc4_d   = skid_pc4_q;

    if (flush) begin
      main_valid_d = 1'b0;
      main_inst_d  = NOP_INST;
      skid_valid_d = 1'b0;
    end else if (xfer_c) begin
      if (skid_valid_q) begin
        // Skid refills main; no accept possible since f_ready is low.
        main_valid_d = 1'b1;
        main_inst_d  = skid_inst_q;
        main_pc_d    = skid_pc_q;
        main_pc4_d   = skid_pc4_q;
        skid_valid_d = 1'b0;
      end else if (accept_c) begin
        main_valid_d = 1'b1;
        main_inst_d  = inst_f;
        main_pc_d    = pc_f;
        main_pc4_d   = pc_plus_4_f;
      end else begin
        // Drained: present a bubble, keep the last PCs.
        main_valid_d = 1'b0;
        main_inst_d  = NOP_INST;
      end
    end else if (!main_valid_q) begin
      // Main empty implies skid empty.
      if (accept_c) begin
        main_valid_d = 1'b1;
        main_inst_d  = inst_f;
        main_pc_d    = pc_f;
        main_pc4_d   = pc_plus_4_f;
      end
    end else if (accept_c) begin
      // Decode stalled with main full: park the beat in the skid.
      skid_valid_d = 1'b1;
      skid_inst_d  = inst_f;
      skid_pc_d    = pc_f;
      skid_pc4_d   = pc_plus_4_f;
    end
  end

  // Entry registers with asynchronous reset to an empty, bubble state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_inst_q  <= NOP_INST;
      main_pc_q    <= '0;
      main_pc4_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= NOP_INST;
      skid_pc_q    <= '0;
      skid_pc4_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_inst_q  <= main_inst_d;
      main_pc_q    <= main_pc_d;
      main_pc4_q   <= main_pc4_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

endmodule

// File: tb/tb_pipe_if_id.sv
// Scoreboard bench for pipe_if_id: directed beats are queued as they are
// expected to be accepted; a monitor pops and compares on every transfer.
module tb_pipe_if_id;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, flush, f_valid, f_ready, d_valid, d_ready;
  logic [31:0] inst_f, pc_f, pc4_f, inst_d, pc_d, pc4_d;

  logic        f_valid64, f_ready64, d_valid64, d_ready64;
  logic [31:0] inst_f64, inst_d64;
  logic [63:0] pc_f64, pc4_f64, pc_d64, pc4_d64;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  pipe_if_id dut (
    .clk(clk), .reset(reset), .flush(flush),
    .f_valid(f_valid), .f_ready(f_ready),
    .inst_f(inst_f), .pc_f(pc_f), .pc_plus_4_f(pc4_f),
    .d_valid(d_valid), .d_ready(d_ready),
    .inst_d(inst_d), .pc_d(pc_d), .pc_plus_4_d(pc4_d)
  );

  pipe_if_id #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .flush(1'b0),
    .f_valid(f_valid64), .f_ready(f_ready64),
    .inst_f(inst_f64), .pc_f(pc_f64), .pc_plus_4_f(pc4_f64),
    .d_valid(d_valid64), .d_ready(d_ready64),
    .inst_d(inst_d64), .pc_d(pc_d64), .pc_plus_4_d(pc4_d64)
  );

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic beat_t mk(logic [31:0] pc);
    beat_t b;
    b.inst = 32'hA000_0000 | pc;
    b.pc   = pc;
    b.pc4  = pc + 32'd4;
    return b;
  endfunction

  // Transfer monitor: every beat leaving must be the oldest expected one.
  always @(negedge clk) begin
    beat_t e;
    if (!reset && !flush && d_valid && d_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got pc %h expected none", pc_d);
      end else begin
        e = exp_q.pop_front();
        check("xfer_inst", 64'(inst_d), 64'(e.inst));
        check("xfer_pc", 64'(pc_d), 64'(e.pc));
        check("xfer_pc4", 64'(pc4_d), 64'(e.pc4));
      end
    end
  end

  // Bubble and stall-stability invariants.
  logic        hold_q = 1'b0;
  logic [95:0] held_q;
  always @(negedge clk) begin
    if (!d_valid) check("bubble_inst", 64'(inst_d), 64'(NOP));
    if (hold_q && d_valid && !reset) check("stall_stable", 64'({inst_d, pc_d} ^ held_q[95:32]), 64'd0);
    hold_q <= d_valid && !d_ready && !reset && !flush;
    held_q <= {inst_d, pc_d, pc4_d};
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] pc);
    beat_t b;
    b       = mk(pc);
    f_valid = v;
    inst_f  = b.inst;
    pc_f    = b.pc;
    pc4_f   = b.pc4;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; d_ready = 1'b0;
    drive(1'b0, 32'h0);
    f_valid64 = 1'b0; d_ready64 = 1'b1; inst_f64 = 32'h1234_5678;
    pc_f64 = 64'hFFFF_FFFF_FFFF_FFFC; pc4_f64 = 64'h0;
    #1;
    check("rst_dvalid", 64'(d_valid), 64'd0);
    check("rst_inst", 64'(inst_d), 64'(NOP));
    check("rst_pc", 64'(pc_d), 64'd0);
    check("rst_pc4", 64'(pc4_d), 64'd0);
    check("rst_fready", 64'(f_ready), 64'd1);
    cyc(); cyc();
    reset = 1'b0;

    // Streaming at full rate.
    d_ready = 1'b1;
    drive(1'b1, 32'h0); exp_q.push_back(mk(32'h0));
    check("stream_fready0", 64'(f_ready), 64'd1);
    cyc();
    check("stream_lat_valid", 64'(d_valid), 64'd1);
    check("stream_lat_pc", 64'(pc_d), 64'h0);
    drive(1'b1, 32'h4); exp_q.push_back(mk(32'h4));
    check("stream_fready1", 64'(f_ready), 64'd1);
    cyc();
    check("stream_pc4", 64'(pc_d), 64'h4);
    drive(1'b1, 32'h8); exp_q.push_back(mk(32'h8));
    check("stream_fready2", 64'(f_ready), 64'd1);
    cyc();
    check("stream_pc8", 64'(pc_d), 64'h8);
    drive(1'b0, 32'h0);
    cyc(); cyc();

    // Stall fills main then skid.
    d_ready = 1'b0;
    drive(1'b1, 32'h10); exp_q.push_back(mk(32'h10));
    cyc();
    drive(1'b1, 32'h14); exp_q.push_back(mk(32'h14));
    check("stall_fready_main", 64'(f_ready), 64'd1);
    cyc();
    drive(1'b0, 32'h0);
    check("skid_fready", 64'(f_ready), 64'd0);
    check("skid_main_pc", 64'(pc_d), 64'h10);
    cyc(); cyc();
    check("skid_fready_held", 64'(f_ready), 64'd0);
    d_ready = 1'b1;
    cyc();
    check("skid_drain_fready", 64'(f_ready), 64'd1);
    check("skid_drain_pc", 64'(pc_d), 64'h14);
    cyc();
    d_ready = 1'b0;
    check("drained_dvalid", 64'(d_valid), 64'd0);
    check("drained_pc_hold", 64'(pc_d), 64'h14);

    // Flush with skid full and a beat presented.
    drive(1'b1, 32'h18); exp_q.push_back(mk(32'h18));
    cyc();
    drive(1'b1, 32'h1C); exp_q.push_back(mk(32'h1C));
    cyc();
    check("flush_pre_fready", 64'(f_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'h20);
    exp_q.delete();
    cyc();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    check("flush_dvalid", 64'(d_valid), 64'd0);
    check("flush_inst", 64'(inst_d), 64'(NOP));
    check("flush_fready", 64'(f_ready), 64'd1);
    check("flush_pc_hold", 64'(pc_d), 64'h18);

    // Flush while f_ready is high: presented beat is dropped.
    drive(1'b1, 32'h24);
    cyc();
    flush = 1'b1;
    drive(1'b1, 32'h28);
    cyc();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    check("flush2_dvalid", 64'(d_valid), 64'd0);
    d_ready = 1'b1;
    cyc(); cyc();
    check("flush2_empty", 64'(d_valid), 64'd0);

    // Skid drain coincides with a new beat that must wait.
    d_ready = 1'b0;
    drive(1'b1, 32'h40); exp_q.push_back(mk(32'h40));
    cyc();
    drive(1'b1, 32'h44); exp_q.push_back(mk(32'h44));
    cyc();
    d_ready = 1'b1;
    drive(1'b1, 32'h30);
    check("simul_fready", 64'(f_ready), 64'd0);
    cyc();
    check("simul_main_pc", 64'(pc_d), 64'h44);
    check("simul_fready_after", 64'(f_ready), 64'd1);
    exp_q.push_back(mk(32'h30));
    cyc();
    drive(1'b0, 32'h0);
    check("simul_late_pc", 64'(pc_d), 64'h30);
    cyc(); cyc();

    // Asynchronous reset with both entries full.
    d_ready = 1'b0;
    drive(1'b1, 32'h50); exp_q.push_back(mk(32'h50));
    cyc();
    drive(1'b1, 32'h54); exp_q.push_back(mk(32'h54));
    cyc();
    drive(1'b0, 32'h0);
    check("areset_pre_fready", 64'(f_ready), 64'd0);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("areset_dvalid", 64'(d_valid), 64'd0);
    check("areset_inst", 64'(inst_d), 64'(NOP));
    check("areset_pc", 64'(pc_d), 64'd0);
    check("areset_pc4", 64'(pc4_d), 64'd0);
    check("areset_fready", 64'(f_ready), 64'd1);
    d_ready = 1'b1;
    drive(1'b1, 32'h5C);
    cyc();
    check("in_reset_no_accept", 64'(d_valid), 64'd0);
    reset = 1'b0;
    drive(1'b1, 32'h60); exp_q.push_back(mk(32'h60));
    cyc();
    drive(1'b0, 32'h0);
    check("post_reset_pc", 64'(pc_d), 64'h60);
    cyc(); cyc();

    // 64-bit PC path.
    f_valid64 = 1'b1;
    cyc();
    f_valid64 = 1'b0;
    check("x64_dvalid", 64'(d_valid64), 64'd1);
    check("x64_pc", pc_d64, 64'hFFFF_FFFF_FFFF_FFFC);
    check("x64_pc4", pc4_d64, 64'h0);
    check("x64_inst", 64'(inst_d64), 64'h1234_5678);
    cyc(); cyc();

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_beats: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
